// File: rtl/vx_multi_fifo_queue.sv
// rtl/vx_multi_fifo_queue.sv - multi-channel FWFT FIFO, NUM_QUEUES circular queues in one shared array
// Optional error flags (overflow/underflow) enabled by macro VX_MULTI_FIFO_ERROR_EN.
module vx_multi_fifo_queue #(
   parameter int DATAW      = 8,
   parameter int SIZE       = 4,
   parameter int NUM_QUEUES = 4,
   parameter int ALM_FULL   = SIZE - 1,
   parameter int ALM_EMPTY  = 1,
   localparam int QIDW      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
   localparam int SIZEW     = $clog2(SIZE + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic [QIDW-1:0]             push_qid,
   input  logic [DATAW-1:0]            data_in,
   input  logic                        pop,
   input  logic [QIDW-1:0]             pop_qid,
   output logic [DATAW-1:0]            data_out,
   output logic [NUM_QUEUES-1:0]       empty,
   output logic [NUM_QUEUES-1:0]       full,
   output logic [NUM_QUEUES-1:0]       alm_empty,
   output logic [NUM_QUEUES-1:0]       alm_full,
`ifdef VX_MULTI_FIFO_ERROR_EN
   output logic [NUM_QUEUES-1:0]       overflow,
   output logic [NUM_QUEUES-1:0]       underflow,
`endif
   output logic [NUM_QUEUES*SIZEW-1:0] size
);

   localparam int PTRW = $clog2(SIZE);
   localparam logic [QIDW:0]    LP_NQ   = (QIDW+1)'(NUM_QUEUES);
   localparam logic [SIZEW-1:0] LP_SIZE = SIZEW'(SIZE);
   localparam logic [SIZEW-1:0] LP_AF   = SIZEW'(ALM_FULL);
   localparam logic [SIZEW-1:0] LP_AE   = SIZEW'(ALM_EMPTY);

   logic [DATAW-1:0]      r_mem [NUM_QUEUES*SIZE];
   logic [PTRW-1:0]       r_rd_ptr [NUM_QUEUES];
   logic [PTRW-1:0]       r_wr_ptr [NUM_QUEUES];
   logic [SIZEW-1:0]      r_count [NUM_QUEUES];
   logic [SIZEW-1:0]      w_count_nxt [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] r_empty;
   logic [NUM_QUEUES-1:0] r_full;
   logic [NUM_QUEUES-1:0] r_alm_empty;
   logic [NUM_QUEUES-1:0] r_alm_full;
   logic [NUM_QUEUES-1:0] w_push_hit;
   logic [NUM_QUEUES-1:0] w_pop_hit;
   logic                  w_push_qid_ok;
   logic                  w_pop_qid_ok;
   logic                  w_same_q;
   logic                  w_push_acc;
   logic                  w_pop_acc;
   logic [QIDW+PTRW-1:0]  w_waddr;
   logic [QIDW+PTRW-1:0]  w_raddr;

   // Out-of-range queue ids are dropped; a full queue still accepts a push when it is popped in the same cycle
   assign w_push_qid_ok = {1'b0, push_qid} < LP_NQ;
   assign w_pop_qid_ok  = {1'b0, pop_qid} < LP_NQ;
   assign w_same_q      = pop && (pop_qid == push_qid);
   assign w_push_acc    = push && w_push_qid_ok && (!r_full[push_qid] || w_same_q);
   assign w_pop_acc     = pop && w_pop_qid_ok && !r_empty[pop_qid];

   // SIZE is a power of two, so queue base + pointer is a plain concatenation
   assign w_waddr  = {push_qid, r_wr_ptr[push_qid]};
   assign w_raddr  = {pop_qid, r_rd_ptr[pop_qid]};
   assign data_out = r_mem[w_raddr];

   // Per-queue hit decode and next occupancy
   always_comb begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
         w_push_hit[q]  = w_push_acc && (push_qid == QIDW'(q));
         w_pop_hit[q]   = w_pop_acc && (pop_qid == QIDW'(q));
         w_count_nxt[q] = r_count[q];
         if (w_push_hit[q] && !w_pop_hit[q]) begin
            w_count_nxt[q] = r_count[q] + SIZEW'(1);
         end else if (w_pop_hit[q] && !w_push_hit[q]) begin
            w_count_nxt[q] = r_count[q] - SIZEW'(1);
         end
      end
   end

   // Shared storage write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_mem[w_waddr] <= data_in;
      end
   end

   // Pointers, counts and flags; flags are computed from the next count so they line up with size
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            r_rd_ptr[q]    <= '0;
            r_wr_ptr[q]    <= '0;
            r_count[q]     <= '0;
            r_alm_full[q]  <= (LP_AF == '0);
         end
         r_empty     <= '1;
         r_full      <= '0;
         r_alm_empty <= '1;
      end else begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            if (w_push_hit[q]) begin
               r_wr_ptr[q] <= r_wr_ptr[q] + PTRW'(1);
            end
            if (w_pop_hit[q]) begin
               r_rd_ptr[q] <= r_rd_ptr[q] + PTRW'(1);
            end
            r_count[q]     <= w_count_nxt[q];
            r_empty[q]     <= (w_count_nxt[q] == '0);
            r_full[q]      <= (w_count_nxt[q] == LP_SIZE);
            r_alm_full[q]  <= (w_count_nxt[q] >= LP_AF);
            r_alm_empty[q] <= (w_count_nxt[q] <= LP_AE);
         end
      end
   end

   // Pack per-queue occupancy onto the flat size bus
   always_comb begin
      size = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         size[q*SIZEW +: SIZEW] = r_count[q];
      end
   end

   assign empty     = r_empty;
   assign full      = r_full;
   assign alm_empty = r_alm_empty;
   assign alm_full  = r_alm_full;

`ifdef VX_MULTI_FIFO_ERROR_EN
   logic [NUM_QUEUES-1:0] r_overflow;
   logic [NUM_QUEUES-1:0] r_underflow;
   logic                  w_overflow_ev;
   logic                  w_underflow_ev;

   assign w_overflow_ev  = push && w_push_qid_ok && r_full[push_qid] && !w_same_q;
   assign w_underflow_ev = pop && w_pop_qid_ok && r_empty[pop_qid];

   // Sticky error bits, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= '0;
         r_underflow <= '0;
      end else begin
         if (w_overflow_ev) begin
            r_overflow[push_qid] <= 1'b1;
         end
         if (w_underflow_ev) begin
            r_underflow[pop_qid] <= 1'b1;
         end
`ifndef SYNTHESIS
         if (w_overflow_ev) begin
            $error("vx_multi_fifo_queue: push to full queue %0d", push_qid);
         end
         if (w_underflow_ev) begin
            $error("vx_multi_fifo_queue: pop of empty queue %0d", pop_qid);
         end
`endif
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

endmodule
